// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: machine-timer interrupt source for the 3-stage pipeline.
// Holds a free-running 64-bit mtime and a 64-bit mtimecmp on the data bus,
// raises trap_handle while mtime >= mtimecmp, and follows the trap through
// entry (trap_taken) and return (is_mret) so each event is delivered once.
// Optional feature macro: TIMER_IRQ_EXT_IRQ_EN adds a synchronized external
// interrupt input that has priority over the timer (mcause 0x8000_000B).
// Register window (byte offsets from BASE_ADDR):
//   0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 status
module timer_irq_ctrl #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    input  logic        trap_taken,
    input  logic        is_mret,
`ifdef TIMER_IRQ_EXT_IRQ_EN
    input  logic        ext_irq,
`endif
    output logic        trap_handle,
    output logic [31:0] irq_cause,
    output logic        timer_pending
);

    localparam logic [15:0] PRESC_MAX   = 16'(PRESCALE - 32'd1);
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [15:0] presc_r;
    logic        tick_s;
    logic [63:0] mtime_r;
    logic [63:0] mtime_next_s;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtimecmp_next_s;
    logic        timer_pending_r;
    state_t      state_r;
    state_t      state_next_s;
    logic        trap_handle_r;
    logic        trap_handle_next_s;
    logic [31:0] irq_cause_r;
    logic [31:0] irq_cause_next_s;
    logic        ext_active_s;

    logic [31:0] off_s;
    logic        sel_mtime_lo_s;
    logic        sel_mtime_hi_s;
    logic        sel_cmp_lo_s;
    logic        sel_cmp_hi_s;
    logic        sel_status_s;
    logic [31:0] rdata_s;

`ifdef TIMER_IRQ_EXT_IRQ_EN
    logic ext_meta_r;
    logic ext_sync_r;

    // Two-flop synchronizer for the asynchronous external interrupt level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_meta_r <= 1'b0;
            ext_sync_r <= 1'b0;
        end else begin
            ext_meta_r <= ext_irq;
            ext_sync_r <= ext_meta_r;
        end
    end

    assign ext_active_s = ext_sync_r;
`else
    assign ext_active_s = 1'b0;
`endif

    // Address decode: only word-aligned offsets inside the window select a register.
    always_comb begin
        off_s          = addr - BASE_ADDR;
        sel_mtime_lo_s = 1'b0;
        sel_mtime_hi_s = 1'b0;
        sel_cmp_lo_s   = 1'b0;
        sel_cmp_hi_s   = 1'b0;
        sel_status_s   = 1'b0;
        case (off_s)
            32'h0000_0000: sel_mtime_lo_s = 1'b1;
            32'h0000_0004: sel_mtime_hi_s = 1'b1;
            32'h0000_0008: sel_cmp_lo_s   = 1'b1;
            32'h0000_000C: sel_cmp_hi_s   = 1'b1;
            32'h0000_0010: sel_status_s   = 1'b1;
            default:       sel_status_s   = 1'b0;
        endcase
    end

    // Combinational read mux of pre-edge register values; forced to zero in reset.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rst && rd_en) begin
            if (sel_mtime_lo_s) begin
                rdata_s = mtime_r[31:0];
            end else if (sel_mtime_hi_s) begin
                rdata_s = mtime_r[63:32];
            end else if (sel_cmp_lo_s) begin
                rdata_s = mtimecmp_r[31:0];
            end else if (sel_cmp_hi_s) begin
                rdata_s = mtimecmp_r[63:32];
            end else if (sel_status_s) begin
                rdata_s = {30'b0, ext_active_s, timer_pending_r};
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign rdata = rdata_s;

    // Prescaler tick: mtime advances on the cycle the counter wraps.
    assign tick_s = (presc_r == PRESC_MAX);

    // Prescale counter running 0..PRESCALE-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= 16'd0;
        end else if (tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Next mtime: a bus write to either half replaces this cycle's increment entirely.
    always_comb begin
        mtime_next_s = mtime_r;
        if (wr_en && sel_mtime_lo_s) begin
            mtime_next_s = {mtime_r[63:32], wdata};
        end else if (wr_en && sel_mtime_hi_s) begin
            mtime_next_s = {wdata, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_next_s = mtime_r + 64'd1;
        end else begin
            mtime_next_s = mtime_r;
        end
    end

    // Next mtimecmp: half-word bus updates only.
    always_comb begin
        mtimecmp_next_s = mtimecmp_r;
        if (wr_en && sel_cmp_lo_s) begin
            mtimecmp_next_s = {mtimecmp_r[63:32], wdata};
        end else if (wr_en && sel_cmp_hi_s) begin
            mtimecmp_next_s = {wdata, mtimecmp_r[31:0]};
        end else begin
            mtimecmp_next_s = mtimecmp_r;
        end
    end

    // Timer state and MTIP, compared on post-update values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_r         <= 64'd0;
            mtimecmp_r      <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_pending_r <= 1'b0;
        end else begin
            mtime_r         <= mtime_next_s;
            mtimecmp_r      <= mtimecmp_next_s;
            timer_pending_r <= (mtime_next_s >= mtimecmp_next_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: trap_taken wins in PENDING; withdrawal only when no source remains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (timer_pending_r || ext_active_s) begin
                    state_next_s = PENDING;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PENDING: begin
                if (trap_taken) begin
                    state_next_s = SERVICE;
                end else if (!timer_pending_r && !ext_active_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PENDING;
                end
            end
            SERVICE: begin
                if (is_mret) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVICE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: request while PENDING, cause held across SERVICE.
    always_comb begin
        trap_handle_next_s = 1'b0;
        irq_cause_next_s   = CAUSE_TIMER;
        case (state_next_s)
            PENDING: begin
                trap_handle_next_s = 1'b1;
                irq_cause_next_s   = ext_active_s ? CAUSE_EXT : CAUSE_TIMER;
            end
            SERVICE: begin
                trap_handle_next_s = 1'b0;
                irq_cause_next_s   = irq_cause_r;
            end
            default: begin
                trap_handle_next_s = 1'b0;
                irq_cause_next_s   = CAUSE_TIMER;
            end
        endcase
    end

    // Registered request and cause outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_handle_r <= 1'b0;
            irq_cause_r   <= CAUSE_TIMER;
        end else begin
            trap_handle_r <= trap_handle_next_s;
            irq_cause_r   <= irq_cause_next_s;
        end
    end

    assign trap_handle   = trap_handle_r;
    assign irq_cause     = irq_cause_r;
    assign timer_pending = timer_pending_r;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl (PRESCALE=1).
module tb_timer_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        trap_taken;
    logic        is_mret;
    logic        trap_handle;
    logic [31:0] irq_cause;
    logic        timer_pending;
`ifdef TIMER_IRQ_EXT_IRQ_EN
    logic        ext_irq;
`endif

    int check_cnt;
    int error_cnt;
    logic th_seen;
    logic [31:0] rd_val;

    timer_irq_ctrl #(.PRESCALE(1), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .rdata         (rdata),
        .trap_taken    (trap_taken),
        .is_mret       (is_mret),
`ifdef TIMER_IRQ_EXT_IRQ_EN
        .ext_irq       (ext_irq),
`endif
        .trap_handle   (trap_handle),
        .irq_cause     (irq_cause),
        .timer_pending (timer_pending)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            error_cnt = error_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] val);
        addr  = BASE + off;
        wdata = val;
        wr_en = 1'b1;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] val);
        addr  = BASE + off;
        rd_en = 1'b1;
        #1;
        val   = rdata;
        rd_en = 1'b0;
    endtask

    initial begin
        check_cnt  = 0;
        error_cnt  = 0;
        rst        = 1'b0;
        addr       = BASE;
        wdata      = 32'h0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        trap_taken = 1'b0;
        is_mret    = 1'b0;
`ifdef TIMER_IRQ_EXT_IRQ_EN
        ext_irq    = 1'b0;
`endif
        step(2);

        // Reset values
        check_val("rst_trap_handle", {63'd0, trap_handle}, 64'd0);
        check_val("rst_irq_cause", {32'd0, irq_cause}, {32'd0, 32'h8000_0007});
        check_val("rst_pending", {63'd0, timer_pending}, 64'd0);
        bus_read(32'h8, rd_val);
        check_val("rst_rdata_gated", {32'd0, rd_val}, 64'd0);

        // Idle 100 cycles: mtime counts every edge, no request
        rst = 1'b1;
        th_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            th_seen = th_seen | trap_handle;
        end
        bus_read(32'h0, rd_val);
        check_val("idle_mtime_lo", {32'd0, rd_val}, 64'd100);
        bus_read(32'h8, rd_val);
        check_val("idle_cmp_lo", {32'd0, rd_val}, {32'd0, 32'hFFFF_FFFF});
        check_val("idle_no_trap", {63'd0, th_seen}, 64'd0);
        bus_read(32'h14, rd_val);
        check_val("unmapped_read", {32'd0, rd_val}, 64'd0);

        // Program compare: mtime 3 -> 4 -> 5 across the three writes
        bus_write(32'h0, 32'd3);
        bus_write(32'hC, 32'd0);
        bus_write(32'h8, 32'd20);
        step(14);
        check_val("mtime_19_no_pend", {63'd0, timer_pending}, 64'd0);
        step(1);
        check_val("mtime_20_pend", {63'd0, timer_pending}, 64'd1);
        check_val("mtime_20_no_trap", {63'd0, trap_handle}, 64'd0);
        step(1);
        check_val("pending_trap", {63'd0, trap_handle}, 64'd1);
        check_val("pending_cause", {32'd0, irq_cause}, {32'd0, 32'h8000_0007});
        bus_read(32'h10, rd_val);
        check_val("status_pend", {32'd0, rd_val}, 64'd1);

        // is_mret in PENDING is ignored
        is_mret = 1'b1;
        step(1);
        is_mret = 1'b0;
        check_val("mret_in_pending", {63'd0, trap_handle}, 64'd1);

        // Trap entry and return
        trap_taken = 1'b1;
        step(1);
        trap_taken = 1'b0;
        check_val("taken_drop", {63'd0, trap_handle}, 64'd0);
        step(10);
        check_val("service_hold", {63'd0, trap_handle}, 64'd0);
        is_mret = 1'b1;
        step(1);
        is_mret = 1'b0;
        check_val("mret_idle", {63'd0, trap_handle}, 64'd0);
        step(1);
        check_val("mret_rearm", {63'd0, trap_handle}, 64'd1);

        // Withdrawal by moving mtimecmp out of reach
        bus_write(32'h8, 32'hFFFF_FFFF);
        check_val("withdraw_pend", {63'd0, timer_pending}, 64'd0);
        check_val("withdraw_th_hold", {63'd0, trap_handle}, 64'd1);
        step(1);
        check_val("withdraw_th_drop", {63'd0, trap_handle}, 64'd0);

        // Carry from lo into hi, write overriding an increment
        bus_write(32'h4, 32'd0);
        bus_write(32'h0, 32'hFFFF_FFFF);
        bus_read(32'h0, rd_val);
        check_val("carry_pre_lo", {32'd0, rd_val}, {32'd0, 32'hFFFF_FFFF});
        step(1);
        bus_read(32'h0, rd_val);
        check_val("carry_lo", {32'd0, rd_val}, 64'd0);
        bus_read(32'h4, rd_val);
        check_val("carry_hi", {32'd0, rd_val}, 64'd1);
        bus_write(32'h0, 32'h1234_5678);
        bus_read(32'h0, rd_val);
        check_val("wr_over_inc_lo", {32'd0, rd_val}, {32'd0, 32'h1234_5678});
        bus_read(32'h4, rd_val);
        check_val("wr_over_inc_hi", {32'd0, rd_val}, 64'd1);
        step(1);
        bus_read(32'h0, rd_val);
        check_val("inc_after_wr", {32'd0, rd_val}, {32'd0, 32'h1234_5679});
        rd_en = 1'b0;
        addr  = BASE;
        #1;
        check_val("rd_en_low", {32'd0, rdata}, 64'd0);
        check_val("hi_compare_pend", {63'd0, timer_pending}, 64'd1);
        check_val("pre_rst_th", {63'd0, trap_handle}, 64'd1);

`ifdef TIMER_IRQ_EXT_IRQ_EN
        check_val("ext_pre_cause", {32'd0, irq_cause}, {32'd0, 32'h8000_0007});
        ext_irq = 1'b1;
        step(3);
        check_val("ext_trap", {63'd0, trap_handle}, 64'd1);
        check_val("ext_cause", {32'd0, irq_cause}, {32'd0, 32'h8000_000B});
        bus_read(32'h10, rd_val);
        check_val("ext_status", {32'd0, rd_val}, 64'd3);
`endif

        // Asynchronous reset while PENDING
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_th", {63'd0, trap_handle}, 64'd0);
        check_val("async_rst_pend", {63'd0, timer_pending}, 64'd0);
        check_val("async_rst_cause", {32'd0, irq_cause}, {32'd0, 32'h8000_0007});

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
